// File: rtl/rand_range_mapper.sv
// Maps buffered 32-bit random words to unbiased integers in [0, N) (Lemire multiply-high + rejection).
// Define RAND_RANGE_STATS_EN to enable the drop_count / reject_count statistics counters.
module rand_range_mapper #(
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned ADDR_SIZE   = 4,
   parameter int unsigned RANGE_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [31:0]            rand_in,
   input  logic                   rand_in_valid,
   input  logic [RANGE_WIDTH-1:0] range_in,
   input  logic                   range_load,
   output logic                   busy,
   output logic [RANGE_WIDTH-1:0] out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ADDR_SIZE:0]     fifo_level,
   output logic [15:0]            drop_count,
   output logic [15:0]            reject_count
);

   localparam int unsigned ProdW = 32 + RANGE_WIDTH;

   typedef enum logic {StRun, StCalc} state_e;

   state_e                 state_q;
   logic                   busy_q;
   logic [RANGE_WIDTH-1:0] range_q;
   logic [RANGE_WIDTH-1:0] thresh_q;
   logic [RANGE_WIDTH-1:0] rem_q;
   logic [31:0]            dividend_q;
   logic [4:0]             iter_q;
   logic [RANGE_WIDTH-1:0] out_data_q;
   logic                   out_valid_q;

   logic [31:0]            fifo_mem [FIFO_DEPTH];
   logic [ADDR_SIZE:0]     wr_ptr_q;
   logic [ADDR_SIZE:0]     rd_ptr_q;
   logic [ADDR_SIZE:0]     level;
   logic                   full;
   logic                   empty;
   logic                   push;
   logic                   pop;
   logic [31:0]            head;

   logic [ProdW-1:0]       prod;
   logic [RANGE_WIDTH-1:0] result;
   logic                   accept;

   logic [RANGE_WIDTH:0]   rem_shift;
   logic [RANGE_WIDTH:0]   rem_diff;
   logic [RANGE_WIDTH-1:0] rem_next;

   // FIFO status, pop/push decisions and the combinational mapping of the head word
   always_comb begin
      level  = wr_ptr_q - rd_ptr_q;
      full   = (level == (ADDR_SIZE+1)'(FIFO_DEPTH));
      empty  = (level == '0);
      head   = fifo_mem[rd_ptr_q[ADDR_SIZE-1:0]];
      // A range load discards the output stage, so hold the head word for the new range
      pop    = (state_q == StRun) && !range_load && !empty && (!out_valid_q || out_ready);
      push   = rand_in_valid && (!full || pop);
      prod   = ProdW'(head) * ProdW'(range_q);
      if (range_q == '0) begin
         result = head[RANGE_WIDTH-1:0];
         accept = 1'b1;
      end else begin
         result = prod[ProdW-1:32];
         accept = (prod[31:0] >= 32'(thresh_q));
      end
   end

   // One restoring-division step per cycle; only the remainder is kept
   always_comb begin
      rem_shift = {rem_q, dividend_q[31]};
      rem_diff  = rem_shift - {1'b0, range_q};
      if (rem_shift >= {1'b0, range_q}) begin
         rem_next = rem_diff[RANGE_WIDTH-1:0];
      end else begin
         rem_next = rem_shift[RANGE_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q[ADDR_SIZE-1:0]] <= rand_in;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StRun;
         busy_q      <= 1'b0;
         range_q     <= '0;
         thresh_q    <= '0;
         rem_q       <= '0;
         dividend_q  <= '0;
         iter_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (range_load) begin
                  state_q     <= StCalc;
                  busy_q      <= 1'b1;
                  range_q     <= range_in;
                  dividend_q  <= 32'd0 - 32'(range_in);
                  rem_q       <= '0;
                  iter_q      <= '0;
                  out_valid_q <= 1'b0;
               end else if (pop && accept) begin
                  out_data_q  <= result;
                  out_valid_q <= 1'b1;
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            StCalc: begin
               if (range_load) begin
                  range_q    <= range_in;
                  dividend_q <= 32'd0 - 32'(range_in);
                  rem_q      <= '0;
                  iter_q     <= '0;
               end else begin
                  rem_q      <= rem_next;
                  dividend_q <= {dividend_q[30:0], 1'b0};
                  iter_q     <= iter_q + 5'd1;
                  if (iter_q == 5'd31) begin
                     state_q  <= StRun;
                     busy_q   <= 1'b0;
                     // N = 0 (pass-through) and N = 1 never reject
                     thresh_q <= (range_q <= RANGE_WIDTH'(1)) ? '0 : rem_next;
                  end
               end
            end
            default: state_q <= StRun;
         endcase
      end
   end

`ifdef RAND_RANGE_STATS_EN
   logic [15:0] drop_q;
   logic [15:0] reject_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         drop_q   <= '0;
         reject_q <= '0;
      end else begin
         if (rand_in_valid && !push && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
         if (pop && !accept && (reject_q != 16'hFFFF)) reject_q <= reject_q + 16'd1;
      end
   end

   assign drop_count   = drop_q;
   assign reject_count = reject_q;
`else
   assign drop_count   = 16'd0;
   assign reject_count = 16'd0;
`endif

   assign busy       = busy_q;
   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign fifo_level = level;

endmodule

// File: tb/tb_rand_range_mapper.sv
// Scoreboard bench for rand_range_mapper: directed words with hand-computed mapped values.
module tb_rand_range_mapper;

`ifdef RAND_RANGE_STATS_EN
   localparam bit StatsEn = 1'b1;
`else
   localparam bit StatsEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] rand_in = '0;
   logic        rand_in_valid = 1'b0;
   logic [15:0] range_in = '0;
   logic        range_load = 1'b0;
   logic        busy;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [4:0]  fifo_level;
   logic [15:0] drop_count;
   logic [15:0] reject_count;

   int          vectors = 0;
   int          miscompares = 0;
   int          n_out = 0;
   logic [15:0] exp_q [$];

   rand_range_mapper dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .rand_in      (rand_in),
      .rand_in_valid(rand_in_valid),
      .range_in     (range_in),
      .range_load   (range_load),
      .busy         (busy),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .fifo_level   (fifo_level),
      .drop_count   (drop_count),
      .reject_count (reject_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every transfer is compared against the head of the scoreboard
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         n_out++;
         if (exp_q.size() == 0) begin
            check("unexpected_output", {16'h0, out_data}, 32'hDEAD_BEEF);
         end else begin
            check("out_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [31:0] w);
      rand_in       = w;
      rand_in_valid = 1'b1;
      tick();
      rand_in_valid = 1'b0;
   endtask

   task automatic load_range(input logic [15:0] n);
      range_in   = n;
      range_load = 1'b1;
      tick();
      range_load = 1'b0;
   endtask

   task automatic count_busy(output int cnt);
      cnt = 0;
      while (busy && cnt < 100) begin
         tick();
         cnt++;
      end
   endtask

   task automatic drain(input string name);
      int cnt = 0;
      while ((exp_q.size() != 0 || out_valid) && cnt < 300) begin
         tick();
         cnt++;
      end
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      int cnt;
      int outs;
      bit bad;

      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_fifo_level", fifo_level, 0);
      check("rst_drop", drop_count, 0);
      check("rst_reject", reject_count, 0);
      reset_n = 1'b1;
      tick();

      // Pass-through with N = 0, two-cycle latency
      out_ready = 1'b1;
      exp_q.push_back(16'h5678);
      push_word(32'h1234_5678);
      check("lat_not_yet", out_valid, 0);
      tick();
      check("lat_valid", out_valid, 1);
      check("lat_data", out_data, 16'h5678);
      drain("drain_pass");
      check("pass_reject", reject_count, 0);

      // N = 6, t = 4: two rejects, then 3 and 5
      load_range(16'd6);
      check("busy_after_load", busy, 1);
      count_busy(cnt);
      check("busy_cycles_n6", cnt, 32);
      exp_q.push_back(16'd3);
      exp_q.push_back(16'd5);
      push_word(32'h0000_0000);
      push_word(32'h8000_0000);
      push_word(32'h8000_0001);
      push_word(32'hFFFF_FFFF);
      drain("drain_n6");
      check("reject_n6", reject_count, StatsEn ? 2 : 0);

      // N = 1: everything maps to 0, nothing rejected
      load_range(16'd1);
      count_busy(cnt);
      check("busy_cycles_n1", cnt, 32);
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(16'd0);
         push_word(32'h1357_9BDF * (i + 1));
      end
      drain("drain_n1");
      check("reject_n1", reject_count, StatsEn ? 2 : 0);

      // N = 0 under backpressure: 1 held + 16 buffered + 3 dropped
      load_range(16'd0);
      count_busy(cnt);
      out_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i < 17) exp_q.push_back(16'(i));
         push_word(32'hA5A5_0000 + i);
      end
      check("full_level", fifo_level, 16);
      check("full_drop", drop_count, StatsEn ? 3 : 0);
      check("full_held", out_data, 16'h0000);
      outs = n_out;
      out_ready = 1'b1;
      drain("drain_full");
      check("full_out_count", n_out - outs, 17);

      // range_load discards the held output and stalls pops; restart mid-CALC
      out_ready = 1'b0;
      push_word(32'h1111_AAAA);
      exp_q.push_back(16'hBBBB);
      push_word(32'h2222_BBBB);
      check("pre_load_valid", out_valid, 1);
      load_range(16'd0);
      check("load_drops_valid", out_valid, 0);
      out_ready = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (out_valid || fifo_level != 5'd1 || !busy) bad = 1'b1;
      end
      check("calc_no_pop", bad, 0);
      load_range(16'd0);
      count_busy(cnt);
      check("busy_restart", cnt, 32);
      drain("drain_restart");

      // Asynchronous reset during CALC with a non-empty FIFO
      out_ready = 1'b0;
      push_word(32'h0000_0001);
      push_word(32'h0000_0002);
      push_word(32'h0000_0003);
      load_range(16'd6);
      tick();
      reset_n = 1'b0;
      #1;
      exp_q.delete();
      check("arst_busy", busy, 0);
      check("arst_valid", out_valid, 0);
      check("arst_level", fifo_level, 0);
      check("arst_drop", drop_count, 0);
      check("arst_reject", reject_count, 0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      out_ready = 1'b1;
      exp_q.push_back(16'hBEEF);
      push_word(32'hCAFE_BEEF);
      drain("drain_post_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/rand_range_mapper.md
Name: rand_range_mapper

Overview:
- Sits directly downstream of the Mersenne-twister generator and consumes its 32-bit words (rand_out/rand_out_valid). The generator has no backpressure and emits 624-word bursts separated by refresh gaps.
- Buffers those words in a small FIFO, maps each one to an unbiased integer in [0, N) using multiply-high with rejection (Lemire method), and presents the result on a valid/ready interface.
- Computes the rejection threshold with an on-block 32-cycle sequential divider whenever a new range is loaded.

Parameters:
- FIFO_DEPTH, 16, FIFO entries; must be a power of 2.
- ADDR_SIZE, 4, log2(FIFO_DEPTH).
- RANGE_WIDTH, 16, width of the range bound N and of out_data.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rand_in  in  32  random word from the generator.
- rand_in_valid  in  1  rand_in is valid this cycle; no backpressure is possible.
- range_in  in  RANGE_WIDTH  bound N; value 0 selects pass-through.
- range_load  in  1  one-cycle strobe that loads range_in.
- busy  out  1  high while the threshold divider runs.
- out_data  out  RANGE_WIDTH  mapped value.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- fifo_level  out  ADDR_SIZE+1  current FIFO occupancy.
- drop_count  out  16  input words lost because the FIFO was full; saturating.
- reject_count  out  16  words discarded by the rejection test; saturating.

Behaviour:
- Reset values: range register = 0, threshold t = 0, state = RUN, FIFO empty, out_valid = 0, out_data = 0, busy = 0, all counts = 0. Reset clears any divider operation in progress.
- Input side:
  - On rand_in_valid, the word is pushed if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Otherwise the word is dropped and drop_count increments, saturating at 0xFFFF.
- States:
  - RUN: normal mapping.
  - CALC: the threshold is being computed.
- Transitions:
  - range_load in RUN: latch range_in, clear out_valid (any pending out_data is discarded), go to CALC with busy = 1.
  - range_load during CALC: latch the new value and restart the 32-cycle count.
  - CALC exits to RUN after exactly 32 cycles; busy falls on the same edge.
  - The FIFO keeps filling in both states; no pops happen in CALC.
- Threshold: t = (2^32 - N) mod N, computed by a 32-iteration restoring division (one quotient bit per cycle) of the 32-bit dividend 0x1_0000_0000 - N. For N = 0 or N = 1, t = 0.
- Mapping (combinational on the FIFO head x): m = x * N, a 48-bit product; lo = m[31:0]; result = m[47:32].
  - For N = 0: result = x[RANGE_WIDTH-1:0] and no rejection.
- Pop condition: state = RUN, FIFO not empty, and (out_valid = 0 or out_ready = 1).
  - On a pop with lo >= t: load out_data with the result and set out_valid = 1.
  - On a pop with lo < t: discard the word and increment reject_count. out_valid goes to 0 if the current output was consumed in that cycle; otherwise it holds.
- Handshake: out_data and out_valid are stable while out_valid = 1 and out_ready = 0. Transfer occurs when out_valid and out_ready are both high.
- Latency: a word sampled at edge E0 into an empty FIFO, with out_valid = 0, produces out_valid = 1 after edge E1 (2-cycle latency). Sustained throughput is 1 word per cycle.
- Simultaneous push and pop on an empty FIFO: the push lands and the pop does not occur that cycle.
- fifo_level counts 0..FIFO_DEPTH.

Optional Feature:
- RAND_RANGE_STATS_EN defined: drop_count and reject_count operate as specified above.
- RAND_RANGE_STATS_EN undefined: both outputs are tied to 0 and the counter logic is removed. Drop and reject behaviour is otherwise unchanged.

Test Plan:
- Reset, N = 0, push 0x12345678 with out_ready = 1 -> out_data = 0x5678 with out_valid high 2 cycles after the push; reject_count = 0.
- Load N = 6 -> busy high for exactly 32 cycles, t = 4. Then push 0x00000000, 0x80000000, 0x80000001, 0xFFFFFFFF -> outputs are 3 then 5; reject_count = 2.
- Load N = 1, push 8 arbitrary words -> 8 outputs, all 0; reject_count = 0.
- N = 0, out_ready = 0, push 20 consecutive words -> 1 word held in the output register plus 16 in the FIFO; fifo_level = 16, drop_count = 3. Release out_ready -> exactly 17 outputs in push order.
- Pulse range_load mid-stream with out_valid = 1 -> out_valid drops next cycle and no pops occur for 32 cycles. Pulse range_load again at cycle 10 of CALC -> busy stays high for 32 more cycles.
- Assert reset_n = 0 during CALC and while the FIFO is non-empty -> immediately busy = 0, out_valid = 0, fifo_level = 0, counts = 0. After release, N = 0 pass-through is active.
